// File: rtl/pe_pkg.sv
// Shared types and constants for the PE drain datapath.
package pe_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      CAPT,
      FLUSH
   } pe_state_t;

   // Saturation words for the 16-bit output format.
   localparam int unsigned                SAT_BW  = 16;
   localparam logic [SAT_BW-1:0] SAT_MAX = 16'h7FFF;
   localparam logic [SAT_BW-1:0] SAT_MIN = 16'h8000;

endpackage

// File: rtl/pe_drain_if.sv
// Valid/ready output stream carrying converted PE results.
interface pe_drain_if #(
   parameter int MUL_BW = 16
) ();

   logic                     out_valid;
   logic signed [MUL_BW-1:0] out_data;
   logic                     out_ready;

   modport master (output out_valid, output out_data, input out_ready);
   modport slave  (input out_valid, input out_data, output out_ready);

endinterface

// File: rtl/pe_drain_fifo.sv
// Output FIFO for pe_drain; pointers carry an extra wrap bit for full/empty.
module pe_drain_fifo #(
   parameter int MUL_BW = 16,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic signed [MUL_BW-1:0] push_data,
   input  logic                     pop,
   output logic signed [MUL_BW-1:0] pop_data,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic        [AW:0]       wr_ptr;
   logic        [AW:0]       rd_ptr;
   logic signed [MUL_BW-1:0] mem [DEPTH];
   logic                     do_pop;
   logic                     do_push;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop   = pop && !empty;
   // A pop frees a slot in the same cycle, so a push into a full FIFO is still taken.
   assign do_push  = push && (!full || do_pop);
   assign pop_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/pe_drain.sv
// Drains a free-running PE accumulator chain into a saturated Q-format output stream.
// Define PE_DRAIN_RND_EN for round-half-up conversion; default truncates (floor).
module pe_drain
   import pe_pkg::*;
#(
   parameter int INT_BW = 5,
   parameter int FRA_BW = 10,
   parameter int MUL_BW = 16,
   parameter int ACC_BW = 32,
   parameter int LAT    = 2,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [7:0]               len,
   input  logic signed [ACC_BW-1:0] o_i,
   pe_drain_if.master               drain,
   output logic                     busy,
   output logic                     done,
   output logic                     sat,
   output logic                     ovf
);

   localparam int EXT_BW   = ACC_BW + 1;
   localparam int SIGN_LSB = INT_BW + FRA_BW;
   localparam int CNT_W    = (LAT > 1) ? $clog2(LAT) : 1;

   localparam logic [MUL_BW-1:0] W_MAX = (MUL_BW == SAT_BW) ? MUL_BW'(SAT_MAX)
                                                          : {1'b0, {(MUL_BW-1){1'b1}}};
   localparam logic [MUL_BW-1:0] W_MIN = (MUL_BW == SAT_BW) ? MUL_BW'(SAT_MIN)
                                                          : {1'b1, {(MUL_BW-1){1'b0}}};

   pe_state_t                state;
   logic [CNT_W-1:0]         cnt;
   logic [7:0]               rem;

   logic signed [EXT_BW-1:0] ext;
   logic signed [EXT_BW-1:0] t;
   logic [EXT_BW-SIGN_LSB-1:0] t_hi;
   logic                     in_range;
   logic signed [MUL_BW-1:0] word;

   logic                     capt;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic                     pop;
   logic                     drop;
   logic signed [MUL_BW-1:0] fifo_data;

`ifdef PE_DRAIN_RND_EN
   localparam logic [EXT_BW-1:0] RND = EXT_BW'(1) << (FRA_BW - 1);
`endif

   always_comb begin
      ext = {o_i[ACC_BW-1], o_i};
`ifdef PE_DRAIN_RND_EN
      ext = ext + $signed(RND);
`endif
      t = ext >>> FRA_BW;
   end

   // In range iff every bit from the output sign position upward matches.
   assign t_hi     = t[EXT_BW-1:SIGN_LSB];
   assign in_range = (t_hi == '0) || (t_hi == '1);
   assign word     = in_range ? t[MUL_BW-1:0] : (t[EXT_BW-1] ? W_MIN : W_MAX);

   assign capt = (state == CAPT);
   assign pop  = !fifo_empty && drain.out_ready;
   assign drop = capt && fifo_full && !pop;

   assign drain.out_valid = !fifo_empty;
   assign drain.out_data  = fifo_data;

   pe_drain_fifo #(
      .MUL_BW (MUL_BW),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (capt),
      .push_data (word),
      .pop       (pop),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         rem   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         sat   <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  rem  <= len;
                  sat  <= 1'b0;
                  ovf  <= 1'b0;
                  busy <= 1'b1;
                  if (len == 8'd0) begin
                     state <= FLUSH;
                  end else if (LAT == 1) begin
                     state <= CAPT;
                  end else begin
                     state <= WAIT;
                     cnt   <= CNT_W'(LAT - 1);
                  end
               end
            end
            WAIT: begin
               cnt <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
                  state <= CAPT;
               end
            end
            CAPT: begin
               rem <= rem - 1'b1;
               if (!in_range) begin
                  sat <= 1'b1;
               end
               if (drop) begin
                  ovf <= 1'b1;
               end
               if (rem == 8'd1) begin
                  state <= FLUSH;
               end
            end
            FLUSH: begin
               if (fifo_empty) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/pe_drain.md
PE_DRAIN -- requirements
Module: pe_drain

Interface
REQ-001 SHALL have parameter INT_BW, default 5, integer bits of the Q-format operand.
REQ-002 SHALL have parameter FRA_BW, default 10, fraction bits of the operand; the accumulator carries 2*FRA_BW fraction bits.
REQ-003 SHALL have parameter MUL_BW, default 16, output word width (1+INT_BW+FRA_BW).
REQ-004 SHALL have parameter ACC_BW, default 32, width of the captured PE accumulator.
REQ-005 SHALL have parameter LAT, default 2, cycles from the start sample to the first capture (LAT>=1).
REQ-006 SHALL have parameter DEPTH, default 4, output FIFO entries (power of two).
REQ-007 SHALL have port clk, input, 1, the single clock.
REQ-008 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-009 SHALL have port start, input, 1, a one-cycle request to begin a drain window.
REQ-010 SHALL have port len, input, 8, the number of results to capture, sampled with start.
REQ-011 SHALL have port o_i, input, ACC_BW signed, the PE o_o chain output.
REQ-012 SHALL have port out_valid, output, 1, FIFO head valid.
REQ-013 SHALL have port out_data, output, MUL_BW signed, FIFO head word.
REQ-014 SHALL have port out_ready, input, 1, consumer accept.
REQ-015 SHALL have port busy, output, 1, high in any state except IDLE.
REQ-016 SHALL have port done, output, 1, a one-cycle pulse at window end.
REQ-017 SHALL have port sat, output, 1, sticky flag: at least one captured word saturated.
REQ-018 SHALL have port ovf, output, 1, sticky flag: at least one capture was dropped because the FIFO was full.

Function
REQ-019 SHALL implement FSM states IDLE, WAIT, CAPT and FLUSH.
REQ-020 SHALL accept start only in IDLE; start in any other state is ignored.
REQ-021 SHALL, on an accepted start, latch len, clear sat and ovf, and move to WAIT with the delay counter set to LAT-1.
REQ-022 SHALL, in WAIT, decrement the counter and move to CAPT on the edge where it reaches 0; if LAT=1, it SHALL go directly from IDLE to CAPT.
REQ-023 SHALL capture o_i on exactly len consecutive edges, at start edge +LAT through +LAT+len-1, then move to FLUSH.
REQ-024 SHALL, with len=0, go from IDLE to FLUSH and assert done one cycle after the start edge; no capture occurs.
REQ-025 SHALL, in FLUSH, wait until the FIFO is empty, pulse done for one cycle, and return to IDLE.
REQ-026 SHALL compute the conversion t = o_i >>> FRA_BW (arithmetic shift), evaluated in ACC_BW+1 bits.
REQ-027 SHALL saturate t above 2^(MUL_BW-1)-1 to 0x7FFF (for MUL_BW=16).
REQ-028 SHALL saturate t below -2^(MUL_BW-1) to 0x8000 (for MUL_BW=16).
REQ-029 SHALL otherwise output the low MUL_BW bits of t.
REQ-030 SHALL set sat on any saturating capture.
REQ-031 SHALL present a captured word on out_data with out_valid high in the cycle after its capture edge when the FIFO was empty (1-cycle latency).
REQ-032 SHALL pop on out_valid and out_ready.
REQ-033 SHALL hold out_data stable while out_valid is high and out_ready is low.
REQ-034 SHALL, on a capture with the FIFO full and no simultaneous pop, drop the word and set ovf; the PE chain is free-running and is never stalled.
REQ-035 SHALL, with the FIFO full and a pop in the same cycle, accept the push with no drop.
REQ-036 SHALL wrap the FIFO read and write pointers modulo DEPTH, with the full/empty distinction made by an extra pointer bit.

Reset
REQ-037 SHALL, on rst high at a clock edge, return to IDLE, empty the FIFO, and clear the counters.
REQ-038 SHALL reset out_valid, busy, done, sat and ovf to 0, and out_data to 0.
REQ-039 SHALL abort any window by reset mid-operation with no done pulse.
REQ-040 SHALL give rst priority over start in the same cycle.

Configuration
REQ-041 SHALL, with macro PE_DRAIN_RND_EN defined, add 2^(FRA_BW-1) to o_i before the shift (round half up, computed in ACC_BW+1 bits so it cannot overflow), then saturate.
REQ-042 SHALL, without PE_DRAIN_RND_EN, truncate (floor).

Structure
REQ-043 SHALL place the state enum (IDLE/WAIT/CAPT/FLUSH) and the MUL_BW saturation max/min constants in shared package pe_pkg.
REQ-044 SHALL implement the FIFO as sub-module pe_drain_fifo (parameters MUL_BW and DEPTH; push, pop, full and empty).

Verification
REQ-045 SHALL cover: start, len=3, LAT=2, o_i = 0x0010_0000, 0xFFF0_0000, 0x0000_0000, out_ready=1 -> out_data 0x0400, 0xFC00, 0x0000 on consecutive cycles; done 1 cycle after the FIFO empties; sat=0.
REQ-046 SHALL cover: o_i = 0x7FFF_FFFF, then 0x8000_0000 -> 0x7FFF, 0x8000; sat=1 until the next start.
REQ-047 SHALL cover: o_i = 0x0000_0200 -> 0x0001 with PE_DRAIN_RND_EN, 0x0000 without it; and 0xFFFF_FE00 -> 0x0000 with it, 0xFFFF without it.
REQ-048 SHALL cover: DEPTH=4, len=6, out_ready=0 -> 4 words kept, ovf=1; then out_ready=1 -> first 4 words delivered in order, then done.
REQ-049 SHALL cover: start with len=0 -> busy for 1 cycle, done pulse, no out_valid; and start asserted during CAPT -> ignored, with the count unchanged.
REQ-050 SHALL cover: rst asserted in the 2nd CAPT cycle of a len=5 window -> next cycle IDLE, out_valid=0, no done pulse; a following start with len=1 works normally.
